mem_lsu_ctrl: RTL and testbench

//  Next-generation MEM-stage load/store controller. Drives the sram_like data port for one
//  in-flight instruction, holds load data when WB stalls, and discards responses belonging
//  to requests orphaned by cancel (flush). Sits between the EXE/MEM pipe register and WB.

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/mem_load_align.sv | 30 +++
 rtl/mem_lsu_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_lsu_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store controller: mem_op field layout,
// access sizes, controller states and small address/data helpers.
package mem_pkg;
    localparam int OP_W       = 5;
    localparam int OP_LOAD    = 4;
    localparam int OP_STORE   = 3;
    localparam int OP_SIZE_HI = 2;
    localparam int OP_SIZE_LO = 1;
    localparam int OP_UNSIGN  = 0;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        if (size == SIZE_WORD) begin
            ok = (addr_lo == 2'b00);
        end else if (size == SIZE_HALF) begin
            ok = ~addr_lo[0];
        end
        return ok;
    endfunction

    // The bus picks the live lanes from the address, so the store value is copied to all of them.
    function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] wd;
        case (size)
            SIZE_BYTE: wd = {4{sd[7:0]}};
            SIZE_HALF: wd = {2{sd[15:0]}};
            default:   wd = sd;
        endcase
        return wd;
    endfunction
endpackage

// File: rtl/mem_load_align.sv
// Lane select and sign/zero extension of a 32-bit read word for byte, half and word loads.
// Purely combinational so the cache refill path can reuse it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        unsign,
    output logic [31:0] result
);
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[gi*8 +: 8];
    end

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (size)
            SIZE_BYTE: result = {{24{~unsign & byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = {{16{~unsign & half_sel[15]}}, half_sel};
            default:   result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store controller: issues one sram_like request per instruction, holds load
// data across WB stalls and drops responses that belong to requests orphaned by a flush.
module mem_lsu_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] PADDR_MASK = 32'h1FFF_FFFF,
    parameter int          MAX_STALE  = 3
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              cancel,
    input  logic [OP_W-1:0]   mem_op,
    input  logic [31:0]       vaddr,
    input  logic [31:0]       store_data,
    input  logic              wb_allow_in,
    output logic              mem_over,
    output logic [31:0]       load_result,
    output logic              adel,
    output logic              ades,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic [31:0]       data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);
    localparam int               CNT_W   = $clog2(MAX_STALE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALE);

    logic        is_load, is_store, unsign, aligned, access, launch;
    logic        stale_ok, own_ok;
    logic [1:0]  size;
    logic [31:0] align_out;

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] stale_cnt_reg, stale_cnt_next;
    logic [31:0]      hold_q_reg, hold_q_next;

    assign is_load  = mem_op[OP_LOAD];
    assign is_store = mem_op[OP_STORE];
    assign size     = mem_op[OP_SIZE_HI:OP_SIZE_LO];
    assign unsign   = mem_op[OP_UNSIGN];
    assign aligned  = addr_aligned(size, vaddr[1:0]);
    assign access   = mem_valid & (is_load | is_store);
    // Depends only on registered state and pipe inputs, never on data_data_ok.
    assign launch   = access & aligned & ~cancel & (stale_cnt_reg < CNT_MAX);
    assign stale_ok = data_data_ok & (stale_cnt_reg != '0);
    assign own_ok   = data_data_ok & (stale_cnt_reg == '0) & (state_reg == WAIT);

    mem_load_align u_load_align (
        .rdata   (data_rdata),
        .addr_lo (vaddr[1:0]),
        .size    (size),
        .unsign  (unsign),
        .result  (align_out)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            stale_cnt_reg <= '0;
            hold_q_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            stale_cnt_reg <= stale_cnt_next;
            hold_q_reg    <= hold_q_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        stale_cnt_next = stale_cnt_reg;
        hold_q_next    = hold_q_reg;
        mem_over       = 1'b0;
        load_result    = '0;
        adel           = 1'b0;
        ades           = 1'b0;
        data_req       = 1'b0;
        data_wr        = 1'b0;
        data_size      = size;
        data_addr      = vaddr & PADDR_MASK;
        data_wdata     = store_replicate(size, store_data);

        // Responses are in order, so the oldest outstanding ones are always the orphans.
        if (stale_ok) begin
            stale_cnt_next = stale_cnt_reg - CNT_ONE;
        end

        case (state_reg)
            IDLE: begin
                adel     = mem_valid & is_load & ~aligned;
                ades     = mem_valid & is_store & ~aligned;
                mem_over = mem_valid & ~(access & aligned);
                data_req = launch;
                data_wr  = is_store;
                if (launch && data_addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cancel) begin
                    state_next = IDLE;
                    if (stale_ok) begin
                        stale_cnt_next = stale_cnt_reg;
                    end else if (!own_ok) begin
                        stale_cnt_next = stale_cnt_reg + CNT_ONE;
                    end
                end else if (own_ok) begin
                    mem_over    = 1'b1;
                    load_result = is_load ? align_out : '0;
                    if (wb_allow_in) begin
                        state_next = IDLE;
                    end else begin
                        hold_q_next = load_result;
                        state_next  = HOLD;
                    end
                end
            end
            HOLD: begin
                mem_over    = 1'b1;
                load_result = hold_q_reg;
                if (wb_allow_in || cancel) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (!resetn) begin
            mem_over    = 1'b0;
            load_result = '0;
            adel        = 1'b0;
            ades        = 1'b0;
            data_req    = 1'b0;
            data_wr     = 1'b0;
            data_size   = '0;
            data_addr   = '0;
            data_wdata  = '0;
        end
    end

    // Outside WAIT a response is only legal when it drains an orphaned request.
    assert property (@(posedge clk) disable iff (!resetn)
        !(data_data_ok && (stale_cnt_reg == '0) && (state_reg != WAIT)));
endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl: inputs change 1 ns after the rising edge, outputs are
// sampled 2 ns later, every expected value is hand-computed.
module tb_mem_lsu_ctrl;
    import mem_pkg::*;

    localparam logic [4:0] OP_LW  = 5'b10100;
    localparam logic [4:0] OP_LH  = 5'b10010;
    localparam logic [4:0] OP_LB  = 5'b10000;
    localparam logic [4:0] OP_LHU = 5'b10011;
    localparam logic [4:0] OP_SB  = 5'b01000;
    localparam logic [4:0] OP_SH  = 5'b01010;
    localparam logic [4:0] OP_SW  = 5'b01100;
    localparam logic [4:0] OP_NOP = 5'b00000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        cancel = 1'b0;
    logic [4:0]  mem_op = OP_NOP;
    logic [31:0] vaddr = '0;
    logic [31:0] store_data = '0;
    logic        wb_allow_in = 1'b1;
    logic [31:0] data_rdata = '0;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic        mem_over, adel, ades, data_req, data_wr;
    logic [31:0] load_result, data_addr, data_wdata;
    logic [1:0]  data_size;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_lsu_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_valid    (mem_valid),
        .cancel       (cancel),
        .mem_op       (mem_op),
        .vaddr        (vaddr),
        .store_data   (store_data),
        .wb_allow_in  (wb_allow_in),
        .mem_over     (mem_over),
        .load_result  (load_result),
        .adel         (adel),
        .ades         (ades),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bus_idle();
        mem_valid    = 1'b0;
        cancel       = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        wb_allow_in  = 1'b1;
    endtask

    // Request accepted in c0, response in c1: minimum latency load.
    task automatic load_fast(input string tag, input logic [4:0] op, input logic [31:0] va,
                             input logic [31:0] rd, input logic [31:0] exp);
        mem_valid = 1'b1; mem_op = op; vaddr = va; data_addr_ok = 1'b1; wb_allow_in = 1'b1;
        settle();
        check({tag, ".req"}, 32'(data_req), 32'd1);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
        settle();
        check({tag, ".over"}, 32'(mem_over), 32'd1);
        check({tag, ".result"}, load_result, exp);
        next_cycle();
        bus_idle();
        $display("txn %s vaddr %h rdata %h expect %h", tag, va, rd, exp);
    endtask

    initial begin
        // Reset: outputs forced low even with a live aligned load presented.
        mem_valid = 1'b1; mem_op = OP_LW; vaddr = 32'h8000_0010; store_data = 32'h1111_2222;
        #3;
        check("rst.req", 32'(data_req), 32'd0);
        check("rst.over", 32'(mem_over), 32'd0);
        check("rst.addr", data_addr, 32'd0);
        check("rst.wdata", data_wdata, 32'd0);
        next_cycle();
        next_cycle();
        bus_idle();
        resetn = 1'b1;
        settle();
        check("rst.state", 32'(dut.state_reg), 32'(IDLE));
        check("rst.stale", 32'(dut.stale_cnt_reg), 32'd0);
        $display("txn reset released");

        // 1: LW, addr_ok c0, data_ok c2.
        mem_valid = 1'b1; mem_op = OP_LW; vaddr = 32'h8000_0010; data_addr_ok = 1'b1;
        settle();
        check("lw.req", 32'(data_req), 32'd1);
        check("lw.addr", data_addr, 32'h0000_0010);
        check("lw.wr", 32'(data_wr), 32'd0);
        check("lw.size", 32'(data_size), 32'd2);
        next_cycle();
        data_addr_ok = 1'b0;
        settle();
        check("lw.c1_req", 32'(data_req), 32'd0);
        check("lw.c1_over", 32'(mem_over), 32'd0);
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        settle();
        check("lw.over", 32'(mem_over), 32'd1);
        check("lw.result", load_result, 32'h1234_5678);
        next_cycle();
        bus_idle();
        $display("txn LW 80000010 -> 12345678");

        // 2: sub-word load extraction.
        load_fast("lb", OP_LB, 32'h8000_0003, 32'h80FF_FFFF, 32'hFFFF_FF80);
        load_fast("lhu", OP_LHU, 32'h8000_0002, 32'h80FF_FFFF, 32'h0000_80FF);
        load_fast("lh", OP_LH, 32'h8000_0000, 32'h1234_8001, 32'hFFFF_8001);

        // 3: stores, misaligned accesses, non-memory op.
        mem_valid = 1'b1; mem_op = OP_SH; vaddr = 32'h8000_0002; store_data = 32'h0000_ABCD;
        data_addr_ok = 1'b1;
        settle();
        check("sh.req", 32'(data_req), 32'd1);
        check("sh.wr", 32'(data_wr), 32'd1);
        check("sh.size", 32'(data_size), 32'd1);
        check("sh.wdata", data_wdata, 32'hABCD_ABCD);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        settle();
        check("sh.over", 32'(mem_over), 32'd1);
        check("sh.result", load_result, 32'd0);
        next_cycle();
        bus_idle();
        $display("txn SH 80000002 wdata ABCDABCD");

        mem_valid = 1'b1; mem_op = OP_SW; vaddr = 32'h8000_0001; store_data = 32'h0000_0001;
        settle();
        check("sw_mis.ades", 32'(ades), 32'd1);
        check("sw_mis.adel", 32'(adel), 32'd0);
        check("sw_mis.req", 32'(data_req), 32'd0);
        check("sw_mis.over", 32'(mem_over), 32'd1);
        mem_op = OP_LW; vaddr = 32'h8000_0002;
        settle();
        check("lw_mis.adel", 32'(adel), 32'd1);
        check("lw_mis.req", 32'(data_req), 32'd0);
        mem_op = OP_NOP;
        settle();
        check("nop.over", 32'(mem_over), 32'd1);
        check("nop.req", 32'(data_req), 32'd0);
        mem_op = OP_SB; vaddr = 32'h8000_0003; store_data = 32'h1234_565A;
        settle();
        check("sb.wdata", data_wdata, 32'h5A5A_5A5A);
        check("sb.size", 32'(data_size), 32'd0);
        next_cycle();
        bus_idle();
        $display("txn misaligned SW/LW, NOP, SB replicate");

        // 4: cancel orphans the first LW; its response is discarded.
        mem_valid = 1'b1; mem_op = OP_LW; vaddr = 32'h8000_0010; data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; cancel = 1'b1;
        settle();
        check("cxl.over", 32'(mem_over), 32'd0);
        next_cycle();
        cancel = 1'b0; vaddr = 32'h8000_0020; data_addr_ok = 1'b1;
        settle();
        check("cxl.stale1", 32'(dut.stale_cnt_reg), 32'd1);
        check("cxl.req2", 32'(data_req), 32'd1);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_DEAD;
        settle();
        check("cxl.stale_over", 32'(mem_over), 32'd0);
        next_cycle();
        data_rdata = 32'h0000_BEEF;
        settle();
        check("cxl.over", 32'(mem_over), 32'd1);
        check("cxl.result", load_result, 32'h0000_BEEF);
        next_cycle();
        bus_idle();
        settle();
        check("cxl.stale0", 32'(dut.stale_cnt_reg), 32'd0);
        $display("txn cancel: DEAD discarded, BEEF delivered");

        // 5: MAX_STALE orphans block launch until one drains.
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_op = OP_LW; vaddr = 32'h8000_0040; data_addr_ok = 1'b1;
            next_cycle();
            data_addr_ok = 1'b0; cancel = 1'b1;
            next_cycle();
            cancel = 1'b0;
        end
        settle();
        check("max.stale3", 32'(dut.stale_cnt_reg), 32'd3);
        check("max.req_blocked", 32'(data_req), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h0000_0001;
        settle();
        check("max.req_drain", 32'(data_req), 32'd0);
        check("max.over_drain", 32'(mem_over), 32'd0);
        next_cycle();
        data_data_ok = 1'b0;
        settle();
        check("max.req_open", 32'(data_req), 32'd1);
        data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("max.stale_over", 32'(mem_over), 32'd0);
            next_cycle();
        end
        data_rdata = 32'h0000_0777;
        settle();
        check("max.over", 32'(mem_over), 32'd1);
        check("max.result", load_result, 32'h0000_0777);
        next_cycle();
        bus_idle();
        $display("txn MAX_STALE block and drain, result 00000777");

        // 6: WB stall holds the result; then async reset in the middle of WAIT.
        mem_valid = 1'b1; mem_op = OP_LW; vaddr = 32'h8000_0080; data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55AA_1234; wb_allow_in = 1'b0;
        settle();
        check("hold.over0", 32'(mem_over), 32'd1);
        check("hold.result0", load_result, 32'h55AA_1234);
        next_cycle();
        data_data_ok = 1'b0; data_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold.over", 32'(mem_over), 32'd1);
            check("hold.result", load_result, 32'h55AA_1234);
            check("hold.req", 32'(data_req), 32'd0);
            next_cycle();
        end
        wb_allow_in = 1'b1;
        settle();
        check("hold.release", 32'(mem_over), 32'd1);
        next_cycle();
        settle();
        check("hold.idle", 32'(dut.state_reg), 32'(IDLE));
        $display("txn WB stall 3 cycles, 55AA1234 held");

        mem_valid = 1'b1; mem_op = OP_LW; vaddr = 32'h8000_0100; data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; cancel = 1'b1;
        next_cycle();
        cancel = 1'b0; data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0;
        settle();
        check("rst2.wait", 32'(dut.state_reg), 32'(WAIT));
        resetn = 1'b0;
        #1;
        check("rst2.req", 32'(data_req), 32'd0);
        check("rst2.over", 32'(mem_over), 32'd0);
        check("rst2.state", 32'(dut.state_reg), 32'(IDLE));
        check("rst2.stale", 32'(dut.stale_cnt_reg), 32'd0);
        next_cycle();
        bus_idle();
        resetn = 1'b1;
        $display("txn reset mid-WAIT");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
